mem_arbiter: RTL and testbench

Two-master arbiter for the single CPU-side memory bus ahead of the address decoder and MMIO mux. It lets a second bus master (e.g. a DMA or debug engine) share the memory and MMIO space with the picorv32. It grants one master at a time with round-robin fairness and registers the request toward the decoder. A watchdog terminates any transaction the addressed core never acknowledges.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bus between one requester and one responder on the CPU-side
// memory path; modports are named from the point of view of each end.
interface mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the CPU-side memory bus: registers the
// owner's request toward the decoder and force-completes unanswered requests.
module mem_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic [1:0]    grant,
    output logic          timeout
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state,      w_state_nxt;
    logic          r_owner,      w_owner_nxt;
    logic          r_last_owner, w_last_owner_nxt;
    logic [CW-1:0] r_cnt,        w_cnt_nxt;
    logic          r_s_valid,    w_s_valid_nxt;
    logic [AW-1:0] r_s_addr,     w_s_addr_nxt;
    logic [DW-1:0] r_s_wdata,    w_s_wdata_nxt;
    logic [SW-1:0] r_s_wstrb,    w_s_wstrb_nxt;
    logic          r_m0_ready,   w_m0_ready_nxt;
    logic          r_m1_ready,   w_m1_ready_nxt;
    logic [DW-1:0] r_m0_rdata,   w_m0_rdata_nxt;
    logic [DW-1:0] r_m1_rdata,   w_m1_rdata_nxt;
    logic [1:0]    r_grant,      w_grant_nxt;
    logic          r_timeout,    w_timeout_nxt;

    logic          w_pick;
    logic          w_expire;
    logic          w_rsp;
    logic [DW-1:0] w_rsp_data;

    // On a tie the master that did not win last time is chosen.
    assign w_pick   = (m0.valid && m1.valid) ? ~r_last_owner : m1.valid;
    assign w_expire = (TIMEOUT_CYCLES != 16'd0) &&
                      ((17'(r_cnt) + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        w_s_valid_nxt    = r_s_valid;
        w_s_addr_nxt     = r_s_addr;
        w_s_wdata_nxt    = r_s_wdata;
        w_s_wstrb_nxt    = r_s_wstrb;
        w_grant_nxt      = r_grant;
        w_m0_ready_nxt   = 1'b0;
        w_m1_ready_nxt   = 1'b0;
        w_m0_rdata_nxt   = '0;
        w_m1_rdata_nxt   = '0;
        w_timeout_nxt    = 1'b0;
        w_rsp            = 1'b0;
        w_rsp_data       = '0;

        case (r_state)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    w_state_nxt      = BUSY;
                    w_owner_nxt      = w_pick;
                    w_last_owner_nxt = w_pick;
                    w_cnt_nxt        = '0;
                    w_s_valid_nxt    = 1'b1;
                    w_s_addr_nxt     = w_pick ? m1.addr  : m0.addr;
                    w_s_wdata_nxt    = w_pick ? m1.wdata : m0.wdata;
                    w_s_wstrb_nxt    = w_pick ? m1.wstrb : m0.wstrb;
                    w_grant_nxt      = w_pick ? 2'b10 : 2'b01;
                end
            end

            BUSY: begin
                // A slave response on the threshold cycle takes priority.
                if (s.ready) begin
                    w_rsp      = 1'b1;
                    w_rsp_data = s.rdata;
                end else if (TIMEOUT_CYCLES != 16'd0) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (w_expire) begin
                        w_rsp         = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end
                end

                if (w_rsp) begin
                    w_state_nxt    = DONE;
                    w_s_valid_nxt  = 1'b0;
                    w_m0_ready_nxt = ~r_owner;
                    w_m1_ready_nxt = r_owner;
                    w_m0_rdata_nxt = r_owner ? '0 : w_rsp_data;
                    w_m1_rdata_nxt = r_owner ? w_rsp_data : '0;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end

            default: begin
                w_state_nxt   = IDLE;
                w_s_valid_nxt = 1'b0;
                w_grant_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
            r_s_valid    <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_wstrb    <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_grant      <= 2'b00;
            r_timeout    <= 1'b0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_s_valid    <= w_s_valid_nxt;
            r_s_addr     <= w_s_addr_nxt;
            r_s_wdata    <= w_s_wdata_nxt;
            r_s_wstrb    <= w_s_wstrb_nxt;
            r_m0_ready   <= w_m0_ready_nxt;
            r_m1_ready   <= w_m1_ready_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_grant      <= w_grant_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign s.valid  = r_s_valid;
    assign s.addr   = r_s_addr;
    assign s.wdata  = r_s_wdata;
    assign s.wstrb  = r_s_wstrb;
    assign m0.ready = r_m0_ready;
    assign m0.rdata = r_m0_rdata;
    assign m1.ready = r_m1_ready;
    assign m1.rdata = r_m1_rdata;
    assign grant    = r_grant;
    assign timeout  = r_timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level arbitration/response model.
module tb_mem_arbiter;
    localparam int T_CYC = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] grant;
    logic       timeout;

    mem_arbiter_if m0_if ();
    mem_arbiter_if m1_if ();
    mem_arbiter_if s_if ();

    mem_arbiter #(.TIMEOUT_CYCLES(16'(T_CYC))) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;       // BUSY cycle (1-based) carrying s_ready; 0 = never
        logic [31:0] srd;
        logic [31:0] exp_rd;
        logic        exp_to;
        int          exp_busy;
    } vec_t;

    vec_t vecs [6];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] st);
        if (m == 0) begin
            m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = st;
        end else begin
            m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = st;
        end
    endtask

    task automatic set_v(input int m, input logic v);
        if (m == 0) m0_if.valid = v;
        else        m1_if.valid = v;
    endtask

    function automatic logic get_ready(input int m);
        return (m == 0) ? m0_if.ready : m1_if.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    function automatic logic get_valid(input int m);
        return (m == 0) ? m0_if.valid : m1_if.valid;
    endfunction

    function automatic logic [31:0] get_addr(input int m);
        return (m == 0) ? m0_if.addr : m1_if.addr;
    endfunction

    task automatic new_req(input int m);
        logic [3:0] st;
        st = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        set_m(m, 1'b1, $urandom, $urandom, st);
    endtask

    // One isolated transaction with a scripted slave latency.
    task automatic run_txn(input int idx, input vec_t v);
        int    busy = 0;
        bit    done = 0;
        int    oth  = (v.m == 0) ? 1 : 0;
        string pre  = $sformatf("vec%0d_", idx);
        set_m(v.m, 1'b1, v.addr, v.wdata, v.wstrb);
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            s_if.ready = 1'b0;
            s_if.rdata = 32'hBAD0_0000 | 32'(c);
            if (s_if.valid) begin
                busy++;
                if (busy == 1) begin
                    chk({pre, "s_addr"},  s_if.addr,  v.addr);
                    chk({pre, "s_wdata"}, s_if.wdata, v.wdata);
                    chk({pre, "s_wstrb"}, 32'(s_if.wstrb), 32'(v.wstrb));
                    chk({pre, "grant"},   32'(grant), (v.m == 0) ? 32'd1 : 32'd2);
                end
                if (busy == v.lat) begin
                    s_if.ready = 1'b1;
                    s_if.rdata = v.srd;
                end
            end else if (busy > 0) begin
                done = 1;
                chk({pre, "owner_ready"}, 32'(get_ready(v.m)), 32'd1);
                chk({pre, "owner_rdata"}, get_rdata(v.m), v.exp_rd);
                chk({pre, "timeout"},     32'(timeout), 32'(v.exp_to));
                chk({pre, "other_ready"}, 32'(get_ready(oth)), 32'd0);
                chk({pre, "other_rdata"}, get_rdata(oth), 32'd0);
                chk({pre, "busy_cycles"}, 32'(busy), 32'(v.exp_busy));
                set_v(v.m, 1'b0);
            end
        end
        if (!done) chk({pre, "txn_completed"}, 32'd0, 32'd1);
        step();
        s_if.ready = 1'b0;
        chk({pre, "ready_single_pulse"}, 32'(get_ready(v.m)), 32'd0);
        chk({pre, "idle_grant"},   32'(grant), 32'd0);
        chk({pre, "idle_s_valid"}, 32'(s_if.valid), 32'd0);
    endtask

    int          k, busy_d, pulses, exp_last, r_w, r_lat, r_busy;
    int          r_gap [2];
    logic        prev_sv, exp_to;
    logic [31:0] got, r_srd;
    bit          seen;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        set_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'd0;

        // Reset values
        #2;
        chk("rst_s_valid",  32'(s_if.valid), 32'd0);
        chk("rst_s_addr",   s_if.addr,  32'd0);
        chk("rst_s_wdata",  s_if.wdata, 32'd0);
        chk("rst_s_wstrb",  32'(s_if.wstrb), 32'd0);
        chk("rst_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_if.ready), 32'd0);
        chk("rst_m0_rdata", m0_if.rdata, 32'd0);
        chk("rst_m1_rdata", m1_if.rdata, 32'd0);
        chk("rst_grant",    32'(grant), 32'd0);
        chk("rst_timeout",  32'(timeout), 32'd0);
        #10 reset_n = 1'b1;

        // Directed vector table
        vecs[0] = '{m:0, addr:32'h4000_0010, wdata:32'h0, wstrb:4'h0, lat:3,
                    srd:32'hA5A5_5A5A, exp_rd:32'hA5A5_5A5A, exp_to:1'b0, exp_busy:3};
        vecs[1] = '{m:1, addr:32'hC300_0000, wdata:32'h0000_0041, wstrb:4'b0001, lat:1,
                    srd:32'h0, exp_rd:32'h0, exp_to:1'b0, exp_busy:1};
        vecs[2] = '{m:0, addr:32'h1000_0000, wdata:32'h0, wstrb:4'h0, lat:0,
                    srd:32'h0, exp_rd:32'h0, exp_to:1'b1, exp_busy:8};
        vecs[3] = '{m:0, addr:32'h2000_0004, wdata:32'h0, wstrb:4'h0, lat:8,
                    srd:32'h1234_5678, exp_rd:32'h1234_5678, exp_to:1'b0, exp_busy:8};
        vecs[4] = '{m:1, addr:32'h0000_0100, wdata:32'hFFFF_FFFF, wstrb:4'hF, lat:9,
                    srd:32'h5555_5555, exp_rd:32'h0, exp_to:1'b1, exp_busy:8};
        vecs[5] = '{m:1, addr:32'h3000_0000, wdata:32'h0, wstrb:4'h0, lat:2,
                    srd:32'hCAFE_F00D, exp_rd:32'hCAFE_F00D, exp_to:1'b0, exp_busy:2};
        step();
        for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

        // Spurious s_ready while idle
        s_if.ready = 1'b1;
        s_if.rdata = 32'hFFFF_0000;
        step();
        s_if.ready = 1'b0;
        chk("spur_s_valid",  32'(s_if.valid), 32'd0);
        chk("spur_grant",    32'(grant), 32'd0);
        chk("spur_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("spur_m0_rdata", m0_if.rdata, 32'd0);
        chk("spur_timeout",  32'(timeout), 32'd0);
        step();
        chk("spur_m0_ready2", 32'(m0_if.ready), 32'd0);
        chk("spur_m1_ready2", 32'(m1_if.ready), 32'd0);

        // Owner drops valid during BUSY
        set_m(0, 1'b1, 32'h7000_0000, 32'h0, 4'h0);
        busy_d = 0; pulses = 0; got = 32'd0;
        for (int c = 0; c < 20; c++) begin
            step();
            s_if.ready = 1'b0;
            if (s_if.valid) begin
                set_v(0, 1'b0);
                busy_d++;
                if (busy_d == 2) begin
                    s_if.ready = 1'b1;
                    s_if.rdata = 32'h0000_0777;
                end
            end
            if (m0_if.ready) begin
                pulses++;
                got = m0_if.rdata;
            end
        end
        chk("drop_ready_pulses", 32'(pulses), 32'd1);
        chk("drop_rdata", got, 32'h0000_0777);

        // Asynchronous reset mid-BUSY, then tie-break and fairness
        set_m(0, 1'b1, 32'h5000_0000, 32'h0, 4'h0);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (s_if.valid) seen = 1;
        end
        chk("arst_busy_reached", 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_s_valid",  32'(s_if.valid), 32'd0);
        chk("arst_grant",    32'(grant), 32'd0);
        chk("arst_m0_ready", 32'(m0_if.ready), 32'd0);
        set_m(1, 1'b1, 32'h6000_0000, 32'h0, 4'h0);
        #3 reset_n = 1'b1;
        k = 0;
        prev_sv = 1'b0;
        for (int c = 0; c < 80 && k < 6; c++) begin
            step();
            s_if.ready = s_if.valid;
            s_if.rdata = 32'd0;
            if (s_if.valid && !prev_sv) begin
                chk($sformatf("fair_grant%0d", k), 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
                k++;
            end
            prev_sv = s_if.valid;
        end
        chk("fair_count", 32'(k), 32'd6);
        set_v(0, 1'b0);
        set_v(1, 1'b0);
        step();
        s_if.ready = 1'b0;
        step();
        step();

        // Randomized traffic against the transaction-level model
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        exp_last = 1;
        prev_sv  = 1'b0;
        r_w = 0; r_lat = 0; r_busy = 0; r_srd = 32'd0;
        r_gap[0] = 0; r_gap[1] = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            s_if.ready = 1'b0;
            s_if.rdata = $urandom;
            if (s_if.valid && !prev_sv) begin
                if (m0_if.valid && m1_if.valid) r_w = 1 - exp_last;
                else                            r_w = m1_if.valid ? 1 : 0;
                chk("rnd_grant",  32'(grant), (r_w == 0) ? 32'd1 : 32'd2);
                chk("rnd_s_addr", s_if.addr, get_addr(r_w));
                exp_last = r_w;
                r_busy   = 0;
                r_lat    = $urandom_range(1, 11);
                r_srd    = $urandom;
            end
            if (s_if.valid) begin
                r_busy++;
                if (r_busy == r_lat) begin
                    s_if.ready = 1'b1;
                    s_if.rdata = r_srd;
                end
            end
            if (!s_if.valid && prev_sv) begin
                exp_to = (r_lat > T_CYC);
                chk("rnd_owner_ready", 32'(get_ready(r_w)), 32'd1);
                chk("rnd_other_ready", 32'(get_ready(1 - r_w)), 32'd0);
                chk("rnd_rdata",   get_rdata(r_w), exp_to ? 32'd0 : r_srd);
                chk("rnd_timeout", 32'(timeout), 32'(exp_to));
                chk("rnd_busy",    32'(r_busy), exp_to ? 32'(T_CYC) : 32'(r_lat));
                if ($urandom_range(0, 1) == 1) begin
                    new_req(r_w);
                end else begin
                    set_v(r_w, 1'b0);
                    r_gap[r_w] = $urandom_range(1, 4);
                end
            end else begin
                chk("rnd_quiet", 32'({m0_if.ready, m1_if.ready, timeout}), 32'd0);
            end
            for (int m = 0; m < 2; m++) begin
                if (!get_valid(m)) begin
                    if (r_gap[m] > 0) r_gap[m]--;
                    else if ($urandom_range(0, 2) == 0) new_req(m);
                end
            end
            prev_sv = s_if.valid;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
